// File: rtl/srio_swrite_pack_pkg.sv
// ---------------------------------------------------------------------------
// srio_swrite_pack_pkg
// Shared HELLO-format SWRITE definitions: ftype/ttype codes, header field
// positions, FSM state encodings and a header builder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package srio_swrite_pack_pkg;

  localparam logic [3:0] c_FTYPE_SWRITE = 4'h6;
  localparam logic [3:0] c_TTYPE_SWRITE = 4'h0;

  localparam int c_HDR_TID_MSB   = 63;
  localparam int c_HDR_TID_LSB   = 56;
  localparam int c_HDR_FTYPE_MSB = 55;
  localparam int c_HDR_FTYPE_LSB = 52;
  localparam int c_HDR_TTYPE_MSB = 51;
  localparam int c_HDR_TTYPE_LSB = 48;
  localparam int c_HDR_PRIO_MSB  = 46;
  localparam int c_HDR_PRIO_LSB  = 45;
  localparam int c_HDR_CRF_BIT   = 44;
  localparam int c_HDR_SIZE_MSB  = 43;
  localparam int c_HDR_SIZE_LSB  = 36;
  localparam int c_HDR_ADDR_MSB  = 31;
  localparam int c_HDR_ADDR_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_DROP  = 3'd2,
    ST_HDR   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Reserved bits (47, 35:32) stay zero.
  function automatic logic [63:0] build_hello_hdr(
    input logic [7:0]  tid,
    input logic [1:0]  prio,
    input logic        crf,
    input logic [7:0]  size,
    input logic [31:0] addr
  );
    logic [63:0] hdr;
    hdr = '0;
    hdr[c_HDR_TID_MSB:c_HDR_TID_LSB]     = tid;
    hdr[c_HDR_FTYPE_MSB:c_HDR_FTYPE_LSB] = c_FTYPE_SWRITE;
    hdr[c_HDR_TTYPE_MSB:c_HDR_TTYPE_LSB] = c_TTYPE_SWRITE;
    hdr[c_HDR_PRIO_MSB:c_HDR_PRIO_LSB]   = prio;
    hdr[c_HDR_CRF_BIT]                   = crf;
    hdr[c_HDR_SIZE_MSB:c_HDR_SIZE_LSB]   = size;
    hdr[c_HDR_ADDR_MSB:c_HDR_ADDR_LSB]   = addr;
    return hdr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/srio_swrite_pack_buf.sv
// ---------------------------------------------------------------------------
// srio_swrite_pack_buf
// Simple dual-port payload buffer with a registered, enable-gated read port.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module srio_swrite_pack_buf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Read data only advances on re, so it doubles as the stalled output holder.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) rdata <= r_mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/srio_swrite_pack.sv
// ---------------------------------------------------------------------------
// srio_swrite_pack
// Store-and-forward packer of AXI-Stream payload into SRIO SWRITE (HELLO).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module srio_swrite_pack
  import srio_swrite_pack_pkg::*;
#(
  parameter int         MAX_BEATS = 32,
  parameter logic [1:0] PRIO      = 2'b01,
  parameter logic       CRF       = 1'b0
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic [63:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic        S_AXIS_TLAST,
  input  logic [3:0]  S_AXIS_TDEST,
  output logic [63:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic        M_AXIS_TLAST,
  input  logic [31:0] cmd,
  input  logic [31:0] addr_0,
  input  logic [31:0] addr_1
);

  localparam int c_AW = $clog2(MAX_BEATS);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_MAX = c_CW'(MAX_BEATS);

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] r_rd_ptr;
  logic            r_cont;
  logic [3:0]      r_dest;
  logic [7:0]      r_tid;
  logic [63:0]     r_hdr;

  logic            w_in_acc;
  logic            w_out_acc;
  logic            w_first;
  logic            w_bad_dest;
  logic [c_CW-1:0] w_cnt_nxt;
  logic [3:0]      w_dest;
  logic [31:0]     w_addr;
  logic [7:0]      w_cnt8;
  logic [7:0]      w_size;
  logic            w_we;
  logic            w_re;
  logic [c_AW-1:0] w_raddr;
  logic [63:0]     w_rd_data;
  logic            w_unused_cmd;

  assign w_unused_cmd = ^cmd[31:2];

  assign S_AXIS_TREADY = (r_state == ST_FILL) || (r_state == ST_DROP);
  assign M_AXIS_TVALID = (r_state == ST_HDR) || (r_state == ST_DRAIN);
  assign M_AXIS_TLAST  = (r_state == ST_DRAIN) && (r_rd_ptr == r_cnt);
  assign M_AXIS_TDATA  = (r_state == ST_DRAIN) ? w_rd_data : r_hdr;

  assign w_in_acc   = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_out_acc  = M_AXIS_TVALID && M_AXIS_TREADY;
  // r_cont marks "inside an input packet": continuation segments keep r_dest.
  assign w_first    = !r_cont;
  assign w_bad_dest = w_first && (S_AXIS_TDEST > 4'd1);
  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign w_dest     = w_first ? S_AXIS_TDEST : r_dest;
  assign w_addr     = (w_dest == 4'd1) ? addr_1 : addr_0;
  // A full 32-beat segment wraps 256 to 0, then minus one gives 0xFF.
  assign w_cnt8     = 8'(w_cnt_nxt);
  assign w_size     = (w_cnt8 << 3) - 8'd1;

  assign w_we    = (r_state == ST_FILL) && w_in_acc && !w_bad_dest;
  assign w_re    = (r_state == ST_HDR) || ((r_state == ST_DRAIN) && M_AXIS_TREADY);
  assign w_raddr = (r_state == ST_HDR) ? '0 : r_rd_ptr[c_AW-1:0];

  srio_swrite_pack_buf #(
    .DEPTH (MAX_BEATS),
    .WIDTH (64)
  ) u_buf (
    .clk   (AXIS_ACLK),
    .we    (w_we),
    .waddr (r_cnt[c_AW-1:0]),
    .wdata (S_AXIS_TDATA),
    .re    (w_re),
    .raddr (w_raddr),
    .rdata (w_rd_data)
  );

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rd_ptr <= '0;
      r_cont   <= 1'b0;
      r_dest   <= 4'd0;
      r_tid    <= 8'd0;
      r_hdr    <= 64'd0;
    end else if (cmd[1]) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rd_ptr <= '0;
      r_cont   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd[0]) r_state <= ST_FILL;
        end
        ST_FILL: begin
          if (w_in_acc) begin
            if (w_first) r_dest <= S_AXIS_TDEST;
            if (w_bad_dest) begin
              if (!S_AXIS_TLAST) r_state <= ST_DROP;
            end else begin
              r_cnt  <= w_cnt_nxt;
              r_cont <= !S_AXIS_TLAST;
              if (S_AXIS_TLAST || (w_cnt_nxt == c_MAX)) begin
                r_state <= ST_HDR;
                r_hdr   <= build_hello_hdr(r_tid, PRIO, CRF, w_size, w_addr);
              end
            end
          end
        end
        ST_DROP: begin
          if (w_in_acc && S_AXIS_TLAST) r_state <= ST_FILL;
        end
        ST_HDR: begin
          if (w_out_acc) begin
            r_state  <= ST_DRAIN;
            r_tid    <= r_tid + 8'd1;
            r_rd_ptr <= c_CW'(1);
          end
        end
        ST_DRAIN: begin
          if (w_out_acc) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_rd_ptr == r_cnt) begin
              r_state  <= ST_FILL;
              r_cnt    <= '0;
              r_rd_ptr <= '0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_srio_swrite_pack.sv
// ---------------------------------------------------------------------------
// tb_srio_swrite_pack
// Directed and randomized-backpressure bench for the SWRITE packer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_srio_swrite_pack;

  localparam logic [31:0] c_A0 = 32'h0000_1000;
  localparam logic [31:0] c_A1 = 32'h0000_2000;

  logic        AXIS_ACLK = 1'b0;
  logic        AXIS_ARESET;
  logic [63:0] S_AXIS_TDATA;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic        S_AXIS_TLAST;
  logic [3:0]  S_AXIS_TDEST;
  logic [63:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b1;
  logic        M_AXIS_TLAST;
  logic [31:0] cmd;
  logic [31:0] addr_0;
  logic [31:0] addr_1;

  int          checks   = 0;
  int          failures = 0;
  logic [64:0] exp_q[$];
  logic [64:0] obs_q[$];
  logic [7:0]  m_tid;
  bit          collect_en = 1'b0;
  bit          rand_bp    = 1'b0;
  bit          bp_level   = 1'b1;
  bit          r_stall_prev = 1'b0;
  logic [64:0] r_prev = '0;

  srio_swrite_pack #(
    .MAX_BEATS (32),
    .PRIO      (2'b01),
    .CRF       (1'b0)
  ) dut (
    .AXIS_ACLK     (AXIS_ACLK),
    .AXIS_ARESET   (AXIS_ARESET),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TDEST  (S_AXIS_TDEST),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .cmd           (cmd),
    .addr_0        (addr_0),
    .addr_1        (addr_1)
  );

  always #5 AXIS_ACLK = ~AXIS_ACLK;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Output-side ready: random or fixed level, updated 2ns after each edge.
  always @(posedge AXIS_ACLK) begin
    #2;
    if (rand_bp) M_AXIS_TREADY = ($urandom_range(0, 99) < 60);
    else         M_AXIS_TREADY = bp_level;
  end

  // Monitor: captures accepted beats and checks hold-while-stalled.
  always @(negedge AXIS_ACLK) begin
    if (collect_en) begin
      if (r_stall_prev) begin
        check("stall_valid", 65'(M_AXIS_TVALID), 65'd1);
        check("stall_hold", {M_AXIS_TLAST, M_AXIS_TDATA}, r_prev);
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) obs_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
      r_stall_prev <= M_AXIS_TVALID && !M_AXIS_TREADY;
      r_prev       <= {M_AXIS_TLAST, M_AXIS_TDATA};
    end else begin
      r_stall_prev <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge AXIS_ACLK);
    #1;
  endtask

  task automatic send_beat(input logic [3:0] d, input logic [63:0] dat, input logic l);
    int   n;
    logic rdy;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = dat;
    S_AXIS_TDEST  = d;
    S_AXIS_TLAST  = l;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 4000) begin
      @(negedge AXIS_ACLK);
      rdy = S_AXIS_TREADY;
      @(posedge AXIS_ACLK);
      #1;
      n++;
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    if (!rdy) check("in_ready_timeout", 65'(rdy), 65'd1);
  endtask

  task automatic send_pkt(input logic [3:0] d, input int n, input logic [63:0] base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      send_beat(d, base + 64'(i), (i == n - 1));
    end
  endtask

  function automatic logic [63:0] hdr_exp(input logic [7:0] tid, input int len, input logic [31:0] a);
    logic [7:0] size;
    size = 8'(len * 8 - 1);
    return {tid, 4'h6, 4'h0, 1'b0, 2'b01, 1'b0, size, 4'h0, a};
  endfunction

  // Reference: splits an input packet into <=32-beat SWRITEs.
  task automatic model_pkt(input logic [3:0] d, input int n, input logic [63:0] base);
    int          rem;
    int          idx;
    int          len;
    logic [31:0] a;
    if (d > 4'd1) return;
    a   = (d == 4'd1) ? c_A1 : c_A0;
    rem = n;
    idx = 0;
    while (rem > 0) begin
      len = (rem > 32) ? 32 : rem;
      exp_q.push_back({1'b0, hdr_exp(m_tid, len, a)});
      for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), base + 64'(idx + k)});
      m_tid = m_tid + 8'd1;
      idx  += len;
      rem  -= len;
    end
  endtask

  task automatic finish_seg(input string tag);
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 30000) begin
      tick();
      n++;
    end
    repeat (6) tick();
    check({tag, "_count"}, 65'(obs_q.size()), 65'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) check(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] base;
    int          d_sel;
    int          len;
    logic [3:0]  d;

    AXIS_ARESET   = 1'b1;
    S_AXIS_TDATA  = '0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TDEST  = '0;
    cmd           = 32'd0;
    addr_0        = c_A0;
    addr_1        = c_A1;
    m_tid         = 8'd0;

    repeat (3) @(posedge AXIS_ACLK);
    #1;
    check("rst_s_tready", 65'(S_AXIS_TREADY), 65'd0);
    check("rst_m_tvalid", 65'(M_AXIS_TVALID), 65'd0);
    check("rst_m_tlast",  65'(M_AXIS_TLAST),  65'd0);
    check("rst_m_tdata",  65'(M_AXIS_TDATA),  65'd0);
    AXIS_ARESET = 1'b0;
    repeat (3) tick();
    check("idle_no_start", 65'(S_AXIS_TREADY), 65'd0);

    collect_en = 1'b1;
    cmd = 32'd1;
    tick();
    check("fill_tready", 65'(S_AXIS_TREADY), 65'd1);

    // 4 beats to addr_0, tid 0
    base = 64'hA5A5_0000_0000_00D0;
    exp_q.push_back({1'b0, 64'h0060_21F0_0000_1000});
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), base + 64'(i)});
    m_tid = 8'd1;
    send_pkt(4'd0, 4, base, 1'b0);
    check("hdr_latency", 65'(M_AXIS_TVALID), 65'd1);
    finish_seg("t1_beat");

    // 1 beat to addr_1, tid 1
    base = 64'hB000_0000_0000_0001;
    exp_q.push_back({1'b0, 64'h0160_2070_0000_2000});
    exp_q.push_back({1'b1, base});
    m_tid = 8'd2;
    send_pkt(4'd1, 1, base, 1'b0);
    finish_seg("t2_beat");

    // dropped branch, then a normal packet
    send_pkt(4'd5, 3, 64'hDEAD_0000_0000_0000, 1'b0);
    base = 64'hC300_0000_0000_0000;
    model_pkt(4'd0, 2, base);
    send_pkt(4'd0, 2, base, 1'b0);
    finish_seg("t3_beat");

    // 40 beats split into 32 + 8
    base = 64'hE400_0000_0000_0000;
    model_pkt(4'd0, 40, base);
    send_pkt(4'd0, 40, base, 1'b0);
    finish_seg("t4_beat");

    rand_bp = 1'b1;
    for (int p = 0; p < 200; p++) begin
      d_sel = $urandom_range(0, 5);
      d     = (d_sel < 3) ? 4'd0 : (d_sel < 5) ? 4'd1 : 4'd9;
      len   = $urandom_range(1, 40);
      base  = 64'hF000_0000_0000_0000 | (64'(p) << 32);
      model_pkt(d, len, base);
      send_pkt(d, len, base, 1'b1);
    end
    finish_seg("t5_beat");
    rand_bp  = 1'b0;
    bp_level = 1'b1;
    tick();

    // soft reset in the middle of DRAIN
    collect_en = 1'b0;
    bp_level   = 1'b0;
    base = 64'h6600_0000_0000_0000;
    send_pkt(4'd0, 8, base, 1'b0);
    check("t6_hdr_valid", 65'(M_AXIS_TVALID), 65'd1);
    bp_level = 1'b1;
    tick();
    tick();
    check("t6_in_drain", {M_AXIS_TLAST, M_AXIS_TDATA}, {1'b0, base + 64'd1});
    bp_level = 1'b0;
    cmd = 32'd2;
    tick();
    cmd = 32'd0;
    check("t6_valid_drop", 65'(M_AXIS_TVALID), 65'd0);
    repeat (4) tick();
    check("t6_stay_idle", 65'(S_AXIS_TREADY), 65'd0);
    check("t6_idle_valid", 65'(M_AXIS_TVALID), 65'd0);
    m_tid = m_tid + 8'd1;
    cmd = 32'd1;
    tick();
    check("t6_restart", 65'(S_AXIS_TREADY), 65'd1);
    bp_level   = 1'b1;
    collect_en = 1'b1;
    base = 64'h7700_0000_0000_0000;
    model_pkt(4'd1, 5, base);
    send_pkt(4'd1, 5, base, 1'b0);
    finish_seg("t6_beat");

    // asynchronous reset in the middle of FILL
    base = 64'h8800_0000_0000_0000;
    for (int i = 0; i < 3; i++) send_beat(4'd0, base + 64'(i), 1'b0);
    #3;
    AXIS_ARESET = 1'b1;
    #1;
    check("arst_s_tready", 65'(S_AXIS_TREADY), 65'd0);
    check("arst_m_tvalid", 65'(M_AXIS_TVALID), 65'd0);
    check("arst_m_tlast",  65'(M_AXIS_TLAST),  65'd0);
    check("arst_m_tdata",  65'(M_AXIS_TDATA),  65'd0);
    tick();
    AXIS_ARESET = 1'b0;
    obs_q.delete();
    exp_q.delete();
    m_tid = 8'd0;
    tick();
    base = 64'h9900_0000_0000_0000;
    model_pkt(4'd0, 2, base);
    send_pkt(4'd0, 2, base, 1'b0);
    finish_seg("t7_beat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
